// File: rtl/arm_instr_encoder_if.sv
// arm_instr_encoder_if: field-bundle stream in, instruction-memory write port out
interface arm_instr_encoder_if #(parameter int ADDR_W = 8);
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_cond;
  logic [1:0]        in_op;
  logic [5:0]        in_funct;
  logic [3:0]        in_rn;
  logic [3:0]        in_rd;
  logic [11:0]       in_src2;
  logic              in_last;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              imem_ack;
  modport master (
    output in_valid, in_cond, in_op, in_funct, in_rn, in_rd, in_src2, in_last, imem_ack,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );
  modport slave (
    input  in_valid, in_cond, in_op, in_funct, in_rn, in_rd, in_src2, in_last, imem_ack,
    output in_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/arm_instr_encoder.sv
// arm_instr_encoder: packs decoder fields into ARM words and writes them into imem.
// Define ARM_ENC_CHECK_EN to reject bundles the decoder cannot execute.
module arm_instr_encoder #(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0,
  parameter int DEPTH     = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  arm_instr_encoder_if.slave   bus,
  output logic [ADDR_W-1:0]    word_count,
  output logic                 done,
  output logic                 wrapped,
  output logic                 err_illegal
);
  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(BASE_ADDR + 4 * (DEPTH - 1));
  state_t state, state_n;
  logic is_bx, illegal, accept, wr_ack, last_q;
  logic [31:0] enc;
  assign is_bx = bus.in_op == 2'b00 && bus.in_funct == 6'b010010 && bus.in_rd == 4'hF;
  assign enc = is_bx ? {bus.in_cond, 8'h12, 12'hFFF, 4'h1, bus.in_src2[3:0]}
                     : {bus.in_cond, bus.in_op, bus.in_funct, bus.in_rn, bus.in_rd, bus.in_src2};
`ifdef ARM_ENC_CHECK_EN
  assign illegal = bus.in_op == 2'b11
    || (bus.in_op == 2'b00 && !is_bx && !(bus.in_funct[4:1] inside {4'b0000, 4'b1100, 4'b0100,
                                                                   4'b0010, 4'b1101, 4'b1010}))
    || (bus.in_op == 2'b00 && bus.in_funct[4:1] == 4'b1010 && !bus.in_funct[0])
    || (bus.in_op == 2'b01 && bus.in_funct[2])
    || (bus.in_op == 2'b10 && !bus.in_funct[5]);
`else
  assign illegal = 1'b0;
`endif
  assign bus.in_ready = state == IDLE && !reset;
  assign bus.imem_we  = state == WRITE;
  assign done         = state == DONE;
  assign accept       = bus.in_valid && bus.in_ready;
  assign wr_ack       = bus.imem_we && bus.imem_ack;
  always_ff @(posedge clk)
    state <= reset ? IDLE : state_n;
  always_comb begin
    state_n = state;
    if (accept) state_n = !illegal ? WRITE : bus.in_last ? DONE : IDLE;
    if (wr_ack) state_n = last_q ? DONE : IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.imem_wdata <= '0;
      bus.imem_addr  <= BASE;
      word_count     <= '0;
      wrapped        <= 1'b0;
      err_illegal    <= 1'b0;
      last_q         <= 1'b0;
    end else begin
      if (accept && !illegal) begin
        bus.imem_wdata <= enc;
        last_q         <= bus.in_last;
      end
      if (accept && illegal) err_illegal <= 1'b1;
      if (wr_ack) begin
        bus.imem_addr <= bus.imem_addr == LAST ? BASE : bus.imem_addr + ADDR_W'(4);
        wrapped       <= wrapped || bus.imem_addr == LAST;
        word_count    <= word_count + ADDR_W'(1);
      end
    end
  end
endmodule
